div_sig_pipe_ctrl: RTL and testbench

- Flow controller for the pipelined radix-4 significand divider (`div_sigcalc`, PIPE_STAGES 0..3).
- Accepts operations over a valid/ready handshake and drives the divider's shared `enable`.
- Tracks per-stage valid bits and carries a sideband tag (sign, exponent, op ID) with latency matched to the datapath.
- Presents results over a valid/ready handshake; stalls the whole pipe on output backpressure.

---
 rtl/div_sig_pipe_ctrl.sv | 113 +++++++++++
 tb/tb_div_sig_pipe_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_sig_pipe_ctrl.sv
// Flow controller for the pipelined radix-4 significand divider: valid/ready in and out,
// per-stage valid bits, a latency-matched sideband tag and saturating activity counters.
module div_sig_pipe_ctrl #(
  parameter int PIPE_STAGES = 3,
  parameter int TAG_W       = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [TAG_W-1:0] in_tag,
  output logic             div_enable,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  input  logic             flush,
  output logic [1:0]       inflight,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] done_cnt
);

  localparam int L  = PIPE_STAGES;
  localparam int VW = (L > 0) ? L : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] done_cnt_r;

  function automatic logic [1:0] popcount(input logic [VW-1:0] bits);
    logic [1:0] n;
    n = 2'd0;
    for (int i = 0; i < VW; i++) begin
      n = n + {1'b0, bits[i]};
    end
    return n;
  endfunction

  generate
    if (L == 0) begin : g_pass
      // Zero-register divider: handshake passes straight through, gated by flush and reset.
      always_comb begin
        div_enable = 1'b1;
        inflight   = 2'd0;
        in_ready   = out_ready & ~flush;
        out_valid  = in_valid & ~flush & ~reset;
        if (reset) begin
          out_tag = {TAG_W{1'b0}};
        end else begin
          out_tag = in_tag;
        end
      end
    end else begin : g_pipe
      logic [L-1:0]     v_r;
      logic [TAG_W-1:0] t_r [L];
      logic             advance_s;

      // Global stall: only a held result at the tail can freeze the pipe.
      always_comb begin
        advance_s  = ~v_r[L-1] | out_ready;
        div_enable = advance_s;
        in_ready   = advance_s & ~flush;
        out_valid  = v_r[L-1];
        out_tag    = t_r[L-1];
        inflight   = popcount(v_r);
      end

      // Valid/tag shift register; flush clears validity, tags are don't-care then.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          v_r <= {L{1'b0}};
          for (int k = 0; k < L; k++) begin
            t_r[k] <= {TAG_W{1'b0}};
          end
        end else if (flush) begin
          v_r <= {L{1'b0}};
        end else if (advance_s) begin
          v_r[0] <= in_valid & in_ready;
          t_r[0] <= in_tag;
          for (int k = 1; k < L; k++) begin
            v_r[k] <= v_r[k-1];
            t_r[k] <= t_r[k-1];
          end
        end else begin
          v_r <= v_r;
        end
      end
    end
  endgenerate

  // Saturating stall and completion counters observed at the output handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
      done_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      if (out_valid && !out_ready && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (out_valid && out_ready && (done_cnt_r != CNT_MAX)) begin
        done_cnt_r <= done_cnt_r + CNT_W'(1'b1);
      end else begin
        done_cnt_r <= done_cnt_r;
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_div_sig_pipe_ctrl.sv
// Scoreboard bench for div_sig_pipe_ctrl: three instances (L=3, L=2, L=0 with 4-bit counters)
// driven by directed vectors; per-instance monitors pop expected tags on output handshakes.
module tb_div_sig_pipe_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // instance a: L=3
  logic a_reset, a_in_valid, a_in_ready, a_div_enable, a_out_valid, a_out_ready, a_flush;
  logic [15:0] a_in_tag, a_out_tag, a_stall_cnt, a_done_cnt;
  logic [1:0]  a_inflight;
  // instance b: L=2
  logic b_reset, b_in_valid, b_in_ready, b_div_enable, b_out_valid, b_out_ready, b_flush;
  logic [15:0] b_in_tag, b_out_tag, b_stall_cnt, b_done_cnt;
  logic [1:0]  b_inflight;
  // instance c: L=0, CNT_W=4
  logic c_reset, c_in_valid, c_in_ready, c_div_enable, c_out_valid, c_out_ready, c_flush;
  logic [15:0] c_in_tag, c_out_tag;
  logic [3:0]  c_stall_cnt, c_done_cnt;
  logic [1:0]  c_inflight;

  logic [15:0] a_q[$];
  logic [15:0] b_q[$];
  logic [15:0] c_q[$];

  div_sig_pipe_ctrl #(.PIPE_STAGES(3), .TAG_W(16), .CNT_W(16)) u_a (
    .clk(clk), .reset(a_reset), .in_valid(a_in_valid), .in_ready(a_in_ready), .in_tag(a_in_tag),
    .div_enable(a_div_enable), .out_valid(a_out_valid), .out_ready(a_out_ready), .out_tag(a_out_tag),
    .flush(a_flush), .inflight(a_inflight), .stall_cnt(a_stall_cnt), .done_cnt(a_done_cnt));

  div_sig_pipe_ctrl #(.PIPE_STAGES(2), .TAG_W(16), .CNT_W(16)) u_b (
    .clk(clk), .reset(b_reset), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_tag(b_in_tag),
    .div_enable(b_div_enable), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_tag(b_out_tag),
    .flush(b_flush), .inflight(b_inflight), .stall_cnt(b_stall_cnt), .done_cnt(b_done_cnt));

  div_sig_pipe_ctrl #(.PIPE_STAGES(0), .TAG_W(16), .CNT_W(4)) u_c (
    .clk(clk), .reset(c_reset), .in_valid(c_in_valid), .in_ready(c_in_ready), .in_tag(c_in_tag),
    .div_enable(c_div_enable), .out_valid(c_out_valid), .out_ready(c_out_ready), .out_tag(c_out_tag),
    .flush(c_flush), .inflight(c_inflight), .stall_cnt(c_stall_cnt), .done_cnt(c_done_cnt));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboards: push on accept, pop on output handshake, drop remaining entries on flush.
  always @(negedge clk) begin : mon_a
    logic [15:0] e;
    if (a_reset) begin
      a_q.delete();
    end else begin
      if (a_in_valid && a_in_ready) a_q.push_back(a_in_tag);
      if (a_out_valid && a_out_ready) begin
        if (a_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL a_unexpected_out actual=%0h expected=none", a_out_tag);
        end else begin
          e = a_q.pop_front();
          check("a_out_tag", 32'(a_out_tag), 32'(e));
        end
      end
      if (a_flush) a_q.delete();
    end
  end

  always @(negedge clk) begin : mon_b
    logic [15:0] e;
    if (b_reset) begin
      b_q.delete();
    end else begin
      if (b_in_valid && b_in_ready) b_q.push_back(b_in_tag);
      if (b_out_valid && b_out_ready) begin
        if (b_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL b_unexpected_out actual=%0h expected=none", b_out_tag);
        end else begin
          e = b_q.pop_front();
          check("b_out_tag", 32'(b_out_tag), 32'(e));
        end
      end
      if (b_flush) b_q.delete();
    end
  end

  always @(negedge clk) begin : mon_c
    logic [15:0] e;
    if (c_reset) begin
      c_q.delete();
    end else begin
      if (c_in_valid && c_in_ready) c_q.push_back(c_in_tag);
      if (c_out_valid && c_out_ready) begin
        if (c_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL c_unexpected_out actual=%0h expected=none", c_out_tag);
        end else begin
          e = c_q.pop_front();
          check("c_out_tag", 32'(c_out_tag), 32'(e));
        end
      end
      if (c_flush) c_q.delete();
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1);
  end

  int e1_inf[7] = '{0, 1, 2, 3, 2, 1, 0};
  int e1_ov[7]  = '{0, 0, 0, 1, 1, 1, 0};
  int e3_inf[9] = '{0, 1, 1, 2, 1, 2, 1, 1, 0};
  int e3_ov[9]  = '{0, 0, 0, 1, 0, 1, 0, 1, 0};
  int e4_ov[4]  = '{0, 0, 1, 0};
  int e5_ov[5]  = '{0, 0, 0, 1, 0};

  initial begin
    a_reset = 1'b1; b_reset = 1'b1; c_reset = 1'b1;
    a_in_valid = 1'b0; a_in_tag = 16'h0; a_out_ready = 1'b0; a_flush = 1'b0;
    b_in_valid = 1'b0; b_in_tag = 16'h0; b_out_ready = 1'b0; b_flush = 1'b0;
    c_in_valid = 1'b0; c_in_tag = 16'h0; c_out_ready = 1'b0; c_flush = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_inflight", 32'(a_inflight), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd1);
    check("rst_div_enable", 32'(a_div_enable), 32'd1);
    check("rst_done_cnt", 32'(a_done_cnt), 32'd0);
    step();
    a_reset = 1'b0; b_reset = 1'b0; c_reset = 1'b0;

    // 1: three back-to-back ops through L=3
    for (int i = 0; i < 7; i++) begin
      a_in_valid = (i < 3); a_in_tag = 16'(i + 1); a_out_ready = 1'b1;
      @(negedge clk);
      check("t1_inflight", 32'(a_inflight), 32'(e1_inf[i]));
      check("t1_out_valid", 32'(a_out_valid), 32'(e1_ov[i]));
      step();
    end
    check("t1_done_cnt", 32'(a_done_cnt), 32'd3);
    check("t1_stall_cnt", 32'(a_stall_cnt), 32'd0);

    // 2: full pipe held by backpressure for 5 cycles
    for (int i = 0; i < 12; i++) begin
      if (i < 3) begin
        a_in_valid = 1'b1; a_in_tag = 16'(16'h000A + i); a_out_ready = 1'b1;
      end else if (i < 8) begin
        a_in_valid = 1'b1; a_in_tag = 16'h000D; a_out_ready = 1'b0;
      end else begin
        a_in_valid = 1'b0; a_out_ready = 1'b1;
      end
      @(negedge clk);
      if (i >= 3 && i < 8) begin
        check("t2_in_ready", 32'(a_in_ready), 32'd0);
        check("t2_div_enable", 32'(a_div_enable), 32'd0);
        check("t2_hold_tag", 32'(a_out_tag), 32'h000A);
        check("t2_inflight", 32'(a_inflight), 32'd3);
      end
      if (i == 8) check("t2_stall_cnt", 32'(a_stall_cnt), 32'd5);
      if (i == 11) check("t2_drained", 32'(a_out_valid), 32'd0);
      step();
    end
    check("t2_done_cnt", 32'(a_done_cnt), 32'd6);

    // 3: alternating bubbles are preserved
    for (int i = 0; i < 9; i++) begin
      a_in_valid = (i < 5) && (i % 2 == 0); a_in_tag = 16'(16'h0031 + i / 2); a_out_ready = 1'b1;
      @(negedge clk);
      check("t3_inflight", 32'(a_inflight), 32'(e3_inf[i]));
      check("t3_out_valid", 32'(a_out_valid), 32'(e3_ov[i]));
      step();
    end
    check("t3_done_cnt", 32'(a_done_cnt), 32'd9);

    // 4: flush with two ops in flight on L=2
    for (int i = 0; i < 7; i++) begin
      b_flush = (i == 2);
      b_in_valid = (i < 4);
      b_in_tag = 16'(16'h0041 + i);
      b_out_ready = (i >= 3);
      @(negedge clk);
      if (i == 2) begin
        check("t4_in_ready_flush", 32'(b_in_ready), 32'd0);
        check("t4_inflight_pre", 32'(b_inflight), 32'd2);
      end
      if (i == 3) check("t4_inflight_post", 32'(b_inflight), 32'd0);
      if (i >= 3) check("t4_out_valid", 32'(b_out_valid), 32'(e4_ov[i-3]));
      step();
    end
    check("t4_stall_cnt", 32'(b_stall_cnt), 32'd1);
    check("t4_done_cnt", 32'(b_done_cnt), 32'd1);

    // 5: asynchronous reset mid-cycle with a full pipe
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1; a_in_tag = 16'(16'h0051 + i); a_out_ready = 1'b1;
      step();
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    check("t5_inflight_pre", 32'(a_inflight), 32'd3);
    #1;
    a_reset = 1'b1;
    #1;
    check("t5_out_valid", 32'(a_out_valid), 32'd0);
    check("t5_inflight", 32'(a_inflight), 32'd0);
    check("t5_out_tag", 32'(a_out_tag), 32'd0);
    check("t5_stall_cnt", 32'(a_stall_cnt), 32'd0);
    check("t5_done_cnt", 32'(a_done_cnt), 32'd0);
    check("t5_in_ready", 32'(a_in_ready), 32'd1);
    a_flush = 1'b1;
    #1;
    check("t5_in_ready_flush", 32'(a_in_ready), 32'd0);
    a_flush = 1'b0;
    @(negedge clk);
    step();
    a_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a_in_valid = (i == 0); a_in_tag = 16'h005A; a_out_ready = 1'b1;
      @(negedge clk);
      check("t5_out_valid_after", 32'(a_out_valid), 32'(e5_ov[i]));
      step();
    end
    check("t5_done_after", 32'(a_done_cnt), 32'd1);

    // 6: L=0 pass-through with saturating 4-bit stall counter
    for (int i = 0; i < 6; i++) begin
      c_in_valid = 1'b1; c_in_tag = 16'h0055; c_out_ready = (i % 2 == 1);
      @(negedge clk);
      check("t6_out_valid", 32'(c_out_valid), 32'd1);
      check("t6_out_tag", 32'(c_out_tag), 32'h0055);
      check("t6_in_ready", 32'(c_in_ready), 32'(i % 2));
      check("t6_div_enable", 32'(c_div_enable), 32'd1);
      check("t6_inflight", 32'(c_inflight), 32'd0);
      step();
    end
    check("t6_stall_cnt", 32'(c_stall_cnt), 32'd3);
    check("t6_done_cnt", 32'(c_done_cnt), 32'd3);
    c_out_ready = 1'b0;
    repeat (12) step();
    check("t6_stall_at_max", 32'(c_stall_cnt), 32'd15);
    repeat (3) step();
    check("t6_stall_saturated", 32'(c_stall_cnt), 32'd15);
    c_flush = 1'b1;
    #1;
    check("t6_flush_out_valid", 32'(c_out_valid), 32'd0);
    check("t6_flush_in_ready", 32'(c_in_ready), 32'd0);
    step();
    c_flush = 1'b0; c_in_valid = 1'b0;
    step();
    check("t6_done_final", 32'(c_done_cnt), 32'd3);

    check("a_q_empty", 32'(a_q.size()), 32'd0);
    check("b_q_empty", 32'(b_q.size()), 32'd0);
    check("c_q_empty", 32'(c_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
